// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : divider_arbiter
// Description : Round-robin arbiter sharing one signed fixed-point divider
//               among NUM_REQ requesters. Handles divide-by-zero locally,
//               bounds the divider wait with a timeout and returns the result
//               as a one-hot response to the granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_divisor,
  input  logic [32*NUM_REQ-1:0] req_dividend,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [47:0]           resp_data,
  output logic                  resp_err,
  output logic                  div_start,
  output logic [31:0]           div_divisor,
  output logic [31:0]           div_dividend,
  input  logic [47:0]           div_result,
  input  logic                  div_valid
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [47:0]   C_SAT_POS    = 48'h7FFF_FFFF_7FFF;
  localparam logic [47:0]   C_SAT_NEG    = 48'h8000_0000_8000;
  localparam logic [GW-1:0] C_LAST_RESET = GW'(NUM_REQ - 1);
  localparam logic [CW-1:0] C_TIMEOUT    = CW'(TIMEOUT);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [GW-1:0] r_last_grant;
  logic [GW-1:0] r_grant;
  logic [31:0]   r_divisor;
  logic [31:0]   r_dividend;
  logic [CW-1:0] r_cnt;
  logic          r_div_valid_q;
  logic [47:0]   r_resp_data;
  logic          r_resp_err;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic          w_found;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_cand;
  int            w_rr_idx;
  logic [31:0]   w_sel_divisor;
  logic [31:0]   w_sel_dividend;
  logic          w_div_zero;
  logic          w_dv_rise;
  logic [CW-1:0] w_cnt_next;
  logic          w_timeout;
  logic          w_req_ready;
  logic          w_resp_valid;
  logic          w_div_start;

  assign w_div_zero = (r_divisor == 32'd0);
  assign w_dv_rise  = div_valid & ~r_div_valid_q;
  assign w_cnt_next = r_cnt + 1'b1;
  // The timeout fires on the WAIT cycle that brings the count to TIMEOUT,
  // so at most TIMEOUT WAIT cycles are spent on one operation.
  assign w_timeout  = (w_cnt_next == C_TIMEOUT);

  // Round-robin search starting one past the last granted requester
  always_comb begin
    w_found  = 1'b0;
    w_pick   = '0;
    w_cand   = '0;
    w_rr_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rr_idx = int'(r_last_grant) + 1 + k;
      if (w_rr_idx >= NUM_REQ) begin
        w_rr_idx = w_rr_idx - NUM_REQ;
      end
      w_cand = GW'(w_rr_idx);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Operand mux selecting the slice of the requester being granted
  always_comb begin
    w_sel_divisor  = '0;
    w_sel_dividend = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_sel_divisor  = req_divisor[32*i +: 32];
        w_sel_dividend = req_dividend[32*i +: 32];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // State register; reset always lands in IDLE, aborting any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = w_div_zero ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (w_dv_rise || w_timeout) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM: output decode, all pulses forced low while reset is held
  always_comb begin
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_div_start  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  w_req_ready  = w_found;
        S_ISSUE: w_div_start  = ~w_div_zero;
        S_RESP:  w_resp_valid = 1'b1;
        default: begin
          w_req_ready  = 1'b0;
          w_resp_valid = 1'b0;
          w_div_start  = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Grant bookkeeping and operand capture on the req_ready cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= C_LAST_RESET;
      r_grant      <= '0;
      r_divisor    <= '0;
      r_dividend   <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_last_grant <= w_pick;
      r_grant      <= w_pick;
      r_divisor    <= w_sel_divisor;
      r_dividend   <= w_sel_dividend;
    end
  end

  // div_valid history, tracked in every state so stale levels never look new
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_valid_q <= 1'b0;
    end else begin
      r_div_valid_q <= div_valid;
    end
  end

  // Timeout counter: cleared on ISSUE, counts every WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= w_cnt_next;
    end
  end

  // Response registers; a divider edge takes priority over a same-cycle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (r_state == S_ISSUE && w_div_zero) begin
      r_resp_data <= r_dividend[31] ? C_SAT_NEG : C_SAT_POS;
      r_resp_err  <= 1'b1;
    end else if (r_state == S_WAIT) begin
      if (w_dv_rise) begin
        r_resp_data <= div_result;
        r_resp_err  <= 1'b0;
      end else if (w_timeout) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // One-hot handshake decoders
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_onehot
    assign req_ready[i]  = w_req_ready  & (w_pick  == GW'(i));
    assign resp_valid[i] = w_resp_valid & (r_grant == GW'(i));
  end

  // Registered outputs are held at zero for as long as reset is asserted
  assign div_start    = w_div_start;
  assign div_divisor  = rst ? 32'd0 : r_divisor;
  assign div_dividend = rst ? 32'd0 : r_dividend;
  assign resp_data    = rst ? 48'd0 : r_resp_data;
  assign resp_err     = rst ? 1'b0  : r_resp_err;

endmodule
`default_nettype wire
